// File: rtl/sar_search_ctrl_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CONV,
        DONE
    } sar_state_t;

    localparam int unsigned SETTLE_W = 4;

    // Comparator flag bundle as sampled by the controller.
    typedef struct packed {
        logic e;
        logic g;
        logic l;
    } cmp_flags_t;

    // High when exactly one of the three comparator flags is set.
    function automatic logic onehot3(input logic e, input logic g, input logic l);
        return (e & ~g & ~l) | (~e & g & ~l) | (~e & ~g & l);
    endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Request/comparator/result bundle for sar_search_ctrl.
// slave = the controller, master = the requester plus external comparator.
interface sar_search_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             cmp_e;
    logic             cmp_g;
    logic             cmp_l;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, cmp_e, cmp_g, cmp_l,
        input  trial, busy, done, result, err
    );

    modport slave (
        input  start, cmp_e, cmp_g, cmp_l,
        output trial, busy, done, result, err
    );
endinterface

// File: rtl/sar_search_ctrl_settle_timer.sv
// Loadable down-counter that times comparator settling between trial codes.
module sar_settle_timer
    import sar_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                en,
    output logic [SETTLE_W-1:0] cnt,
    output logic                zero_c
);

    logic [SETTLE_W-1:0] cnt_q;

    // Load takes priority; otherwise count down while enabled, stopping at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - SETTLE_W'(1);
        end
    end

    assign cnt    = cnt_q;
    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial codes into an
// external comparator and resolves its unknown operand MSB first.
// Optional build macro: SAR_EARLY_EXIT_EN (finish as soon as the comparator
// reports equality).
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 0
) (
    input  logic           clk,
    input  logic           rst,
    sar_search_ctrl_if.slave bus
);

    localparam logic [WIDTH-1:0]    MSB_BIT    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE);
    // State entered after each new trial code: wait for settling only if asked to.
    localparam sar_state_t          STEP_STATE = (SETTLE != 0) ? sar_pkg::SETTLE : CONV;

    sar_state_t          state_q, state_d;
    logic [WIDTH-1:0]    trial_q, trial_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [SETTLE_W-1:0] tmr_cnt;
    logic                tmr_zero_c;
    logic                tmr_load_c;

    cmp_flags_t          flags_c;
    logic                onehot_c;
    logic [WIDTH-1:0]    kept_c;
    logic                last_c;
    logic                exit_c;
    logic                settle_end_c;

    assign flags_c      = '{e: bus.cmp_e, g: bus.cmp_g, l: bus.cmp_l};
    assign onehot_c     = onehot3(flags_c.e, flags_c.g, flags_c.l);
    // "less" means the trial overshot, so the bit under test is dropped.
    assign kept_c       = flags_c.l ? (trial_q & ~mask_q) : trial_q;
    assign last_c       = (mask_q == WIDTH'(1));
    assign settle_end_c = (tmr_cnt == SETTLE_W'(1)) || tmr_zero_c;

`ifdef SAR_EARLY_EXIT_EN
    // Equality means the remaining low bits are zero, so the trial is the answer.
    assign exit_c = flags_c.e;
`else
    assign exit_c = 1'b0;
`endif

    sar_settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (SETTLE_LD),
        .en       (state_q == sar_pkg::SETTLE),
        .cnt      (tmr_cnt),
        .zero_c   (tmr_zero_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            mask_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = STEP_STATE;
                end
            end
            sar_pkg::SETTLE: begin
                if (settle_end_c) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (!onehot_c || exit_c || last_c) begin
                    state_d = DONE;
                end else begin
                    state_d = STEP_STATE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and search registers.
    always_comb begin
        trial_d    = trial_q;
        mask_d     = mask_q;
        result_d   = result_q;
        err_d      = err_q;
        tmr_load_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    trial_d    = MSB_BIT;
                    mask_d     = MSB_BIT;
                    err_d      = 1'b0;
                    tmr_load_c = 1'b1;
                end
            end
            CONV: begin
                if (!onehot_c) begin
                    err_d    = 1'b1;
                    result_d = trial_q & ~mask_q;
                end else if (exit_c) begin
                    result_d = trial_q;
                end else if (last_c) begin
                    result_d = kept_c;
                end else begin
                    mask_d     = mask_q >> 1;
                    trial_d    = kept_c | (mask_q >> 1);
                    tmr_load_c = 1'b1;
                end
            end
            default: begin
            end
        endcase
        busy_d = (state_d == sar_pkg::SETTLE) || (state_d == CONV);
        done_d = (state_d == DONE);
    end

    assign bus.trial  = trial_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation controller that drives trial codes into an external magnitude comparator and uses its equal/greater/less results to recover the comparator's unknown "a" operand.
- The block sends `trial` to the comparator's "b" operand and samples the comparator flags.
- One bit is resolved per compare step, MSB first.
- Used for threshold search, SAR-ADC style conversion and the comparator bring-up benches.

Parameters:
- WIDTH, 4, operand width in bits; must be ≥ 2.
- SETTLE, 0, extra wait cycles between a new trial code and sampling the flags (0 = purely combinational comparator); range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new search; accepted only in IDLE.
- cmp_e  in  1  comparator flag, a == trial.
- cmp_g  in  1  comparator flag, a > trial.
- cmp_l  in  1  comparator flag, a < trial.
- trial  out  WIDTH  registered code driven to the comparator "b" input.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  WIDTH  resolved value; held until the next accepted start.
- err  out  1  sticky; flags were not one-hot when sampled; cleared on the next accepted start.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, trial=0, result=0, busy=0, done=0, err=0, mask=0, settle counter=0. Reset during CONV aborts immediately with no done pulse.
- States: IDLE, SETTLE, CONV, DONE.
- IDLE, start=1:
  - trial <= 1<<(WIDTH-1), mask <= 1<<(WIDTH-1), err <= 0, counter <= SETTLE.
  - Next state is SETTLE if SETTLE>0, else CONV.
  - busy=1 from the next cycle.
- SETTLE: counter decrements each cycle; go to CONV when it reaches 1.
- CONV samples {cmp_e,cmp_g,cmp_l}:
  - Not one-hot: err <= 1, result <= trial & ~mask, go to DONE.
  - cmp_l=1: the current mask bit is cleared in the accumulated value. cmp_e or cmp_g: the bit is kept.
  - mask==1 (LSB): result <= final value, go to DONE.
  - Otherwise: mask <= mask>>1, trial <= (kept value) | (mask>>1), reload counter, go to SETTLE or CONV.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. trial holds its last value.
- Latency with SETTLE=0 and no early exit:
  - WIDTH CONV cycles.
  - done asserts WIDTH+1 cycles after the start-accept edge.
- Latency in general: WIDTH·(SETTLE+1)+1 cycles.
- start while not IDLE is ignored, including in the DONE cycle.
- result and err update only when entering DONE.
- Arithmetic is unsigned, WIDTH bits, with no overflow possible.
- a=0 resolves to 0 and a=all-ones resolves to all-ones.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: in CONV, a one-hot cmp_e=1 sets result <= trial and jumps straight to DONE. Remaining bits are zero, which is correct by construction.
- Undefined: cmp_e is treated as "keep bit" and all WIDTH steps always run, giving fixed latency.
- Error checking is identical in both builds.

Decomposition:
- Package sar_pkg holds:
  - state enum sar_state_t {IDLE, SETTLE, CONV, DONE};
  - localparam SETTLE_W=4;
  - a flag-decode function onehot3(e,g,l).
- Sub-module sar_settle_timer is the loadable down-counter with a zero flag, instantiated once.
- The comparator itself stays external. Benches instantiate the existing comparator module alongside this block.

Test Plan:
- WIDTH=4, SETTLE=0, no macro, a=4'hB:
  - trial sequence 8,C,A,B on consecutive cycles;
  - done 5 cycles after start;
  - result=4'hB, err=0.
- Boundary values:
  - a=4'h0: trials 8,4,2,1, result=0.
  - a=4'hF: trials 8,C,E,F, result=F.
  - Both cases give identical latency.
- SAR_EARLY_EXIT_EN defined, a=4'h8: cmp_e on the first trial gives done 2 cycles after start, result=8. Repeating with a=4'h3 still takes the full latency.
- SETTLE=2, a=4'h5:
  - each trial is held 3 cycles before its decision;
  - done at 4·3+1=13 cycles after start;
  - result=5.
- Flag errors:
  - Force cmp_g=cmp_l=1 on the second compare: err=1, done pulses, result=4'h8 (for a≥8). err stays high until the next start, then clears.
  - Separately, force all flags to 0 on a compare: err=1.
- Control boundaries:
  - Assert start while busy: ignored, result unchanged.
  - Assert rst mid-CONV: next cycle is IDLE with all outputs zero and no done pulse.
  - A fresh start afterwards completes normally.
